bloco_controle: RTL and testbench



---
 rtl/bloco_controle.sv | 90 +++++++++
 tb/tb_bloco_controle.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/bloco_controle.sv
// bloco_controle: traffic-light control FSM sequencing the 7 s / 5 s / 0.5 s timers.
// Optional pedestrian-request gating of the green phase under `PED_REQ_EN.
module bloco_controle #(
    parameter int YELLOW_HALVES = 4,
    parameter int PED_BLINKS    = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic fim_7s,
    input  logic fim_5s,
    input  logic fim_05s,
`ifdef PED_REQ_EN
    input  logic pedido_pedestre,
    output logic pedido_pendente,
`endif
    output logic load_Reg7s,
    output logic clear_Reg7s,
    output logic load_Reg5s,
    output logic clear_Reg5s,
    output logic load_Reg05s,
    output logic clear_Reg05s,
    output logic carro_verde,
    output logic carro_amarelo,
    output logic carro_vermelho,
    output logic pedestre_verde,
    output logic pedestre_vermelho
);
    typedef enum logic [1:0] {VERDE, AMARELO, VERMELHO, PISCA} state_t;
    localparam logic [10:0] RST_OUTS = 11'b01000010001;
    state_t st, st_n;
    logic ent, ent_n, fim, go, last, req_ok;
    logic [3:0] hc, hc_n;
    logic [10:0] outs, outs_n;
`ifdef PED_REQ_EN
    logic pend, pend_n;
    assign req_ok = st != VERDE || pend || pedido_pedestre;
    assign pedido_pendente = pend;
`else
    assign req_ok = 1'b1;
`endif
    always_comb begin
        fim  = st == VERDE ? fim_7s : st == VERMELHO ? fim_5s : fim_05s;
        go   = !ent && fim && req_ok;
        last = hc == (st == AMARELO ? 4'(YELLOW_HALVES - 1) : 4'(PED_BLINKS - 1));
        st_n  = st;
        hc_n  = hc;
        ent_n = go;
        if (go) begin
            case (st)
                VERDE:    st_n = AMARELO;
                VERMELHO: begin st_n = PISCA; hc_n = 4'd0; end
                AMARELO, PISCA: begin
                    hc_n = last ? 4'd0 : hc + 4'd1;
                    st_n = !last ? st : st == AMARELO ? VERMELHO : VERDE;
                end
            endcase
        end
        // outputs are decoded from the next state so they leave the flops aligned with it
        outs_n = {st_n == VERDE && !ent_n, st_n == VERDE && ent_n,
                  st_n == VERMELHO && !ent_n, st_n == VERMELHO && ent_n,
                  st_n[0] && !ent_n, st_n[0] && ent_n,
                  st_n == VERDE, st_n == AMARELO, st_n[1], st_n == VERMELHO,
                  st_n == PISCA ? hc_n[0] : st_n != VERMELHO};
`ifdef PED_REQ_EN
        pend_n = (st == AMARELO && st_n == VERMELHO) ? 1'b0 :
                 (pedido_pedestre && !st[1]) ? 1'b1 : pend;
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st   <= VERDE;
            ent  <= 1'b1;
            hc   <= 4'd0;
            outs <= RST_OUTS;
`ifdef PED_REQ_EN
            pend <= 1'b0;
`endif
        end else begin
            st   <= st_n;
            ent  <= ent_n;
            hc   <= hc_n;
            outs <= outs_n;
`ifdef PED_REQ_EN
            pend <= pend_n;
`endif
        end
    end
    assign {load_Reg7s, clear_Reg7s, load_Reg5s, clear_Reg5s, load_Reg05s, clear_Reg05s,
            carro_verde, carro_amarelo, carro_vermelho, pedestre_verde, pedestre_vermelho} = outs;
endmodule

// File: tb/tb_bloco_controle.sv
// tb_bloco_controle: scoreboard bench for bloco_controle with a behavioural reference model.
module tb_bloco_controle;
    localparam int YH = 4;
    localparam int PB = 6;
    localparam logic [10:0] RST_W = 11'b01000010001;
    logic clk = 1'b0, rst = 1'b1;
    logic fim_7s = 1'b0, fim_5s = 1'b0, fim_05s = 1'b0, ped = 1'b0;
    logic load_Reg7s, clear_Reg7s, load_Reg5s, clear_Reg5s, load_Reg05s, clear_Reg05s;
    logic carro_verde, carro_amarelo, carro_vermelho, pedestre_verde, pedestre_vermelho;
    logic pend_o;
    logic [10:0] dout;
    int n_chk = 0, n_pass = 0;
    logic [11:0] sb[$];
    int m_st, m_hc;
    bit m_ent, m_pend;
    always #5 clk = ~clk;
    bloco_controle #(.YELLOW_HALVES(YH), .PED_BLINKS(PB)) dut (
        .clk(clk), .rst(rst), .fim_7s(fim_7s), .fim_5s(fim_5s), .fim_05s(fim_05s),
`ifdef PED_REQ_EN
        .pedido_pedestre(ped), .pedido_pendente(pend_o),
`endif
        .load_Reg7s(load_Reg7s), .clear_Reg7s(clear_Reg7s),
        .load_Reg5s(load_Reg5s), .clear_Reg5s(clear_Reg5s),
        .load_Reg05s(load_Reg05s), .clear_Reg05s(clear_Reg05s),
        .carro_verde(carro_verde), .carro_amarelo(carro_amarelo), .carro_vermelho(carro_vermelho),
        .pedestre_verde(pedestre_verde), .pedestre_vermelho(pedestre_vermelho));
`ifndef PED_REQ_EN
    assign pend_o = 1'b0;
`endif
    assign dout = {load_Reg7s, clear_Reg7s, load_Reg5s, clear_Reg5s, load_Reg05s, clear_Reg05s,
                   carro_verde, carro_amarelo, carro_vermelho, pedestre_verde, pedestre_vermelho};
    task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask
    task automatic model_reset();
        m_st = 0; m_ent = 1'b1; m_hc = 0; m_pend = 1'b0;
    endtask
    // bit order: load7 clr7 load5 clr5 load05 clr05 cv ca cr pv pr
    function automatic logic [10:0] model_word();
        logic [10:0] w = '0;
        case (m_st)
            0: begin w[m_ent ? 9 : 10] = 1'b1; w[4] = 1'b1; w[0] = 1'b1; end
            1: begin w[m_ent ? 5 : 6] = 1'b1; w[3] = 1'b1; w[0] = 1'b1; end
            2: begin w[m_ent ? 7 : 8] = 1'b1; w[2] = 1'b1; w[1] = 1'b1; end
            default: begin w[m_ent ? 5 : 6] = 1'b1; w[2] = 1'b1; w[0] = (m_hc % 2) == 1; end
        endcase
        return w;
    endfunction
    task automatic model_step(bit f7, bit f5, bit f05, bit p);
        bit own = m_st == 0 ? f7 : m_st == 2 ? f5 : f05;
        bit ok = 1'b1;
`ifdef PED_REQ_EN
        ok = m_st != 0 || m_pend || p;
        if (m_st <= 1 && p) m_pend = 1'b1;
`endif
        if (!m_ent && own && ok) begin
            m_ent = 1'b1;
            if (m_st == 0) m_st = 1;
            else if (m_st == 2) begin m_st = 3; m_hc = 0; end
            else if (m_hc == (m_st == 1 ? YH : PB) - 1) begin
                m_st = m_st == 1 ? 2 : 0;
                m_hc = 0;
                if (m_st == 2) m_pend = 1'b0;
            end else m_hc++;
        end else m_ent = 1'b0;
    endtask
    task automatic cyc(bit f7, bit f5, bit f05, bit p);
        logic [11:0] e;
        fim_7s = f7; fim_5s = f5; fim_05s = f05; ped = p;
        model_step(f7, f5, f05, p);
        sb.push_back({m_pend, model_word()});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("out", 16'(dout), 16'(e[10:0]));
        check("pend", 16'(pend_o), 16'(e[11]));
        check("one_car", 16'($countones({carro_verde, carro_amarelo, carro_vermelho})), 16'd1);
        check("ped_excl", 16'(pedestre_verde & pedestre_vermelho), 16'd0);
        @(negedge clk);
    endtask
    task automatic rand_run(int n);
        repeat (n) cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0);
    endtask
    initial begin
        int n;
        logic [5:0] pat;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst", 16'(dout), 16'(RST_W));
        check("rst_pend", 16'(pend_o), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 0, 0, 0);
        check("stale7", 16'(carro_verde & load_Reg7s), 16'd1);
        cyc(1, 0, 0, 1);
        check("amarelo", 16'(carro_amarelo), 16'd1);
        n = clear_Reg05s ? 1 : 0;
        repeat (YH) begin
            cyc(1, 1, 0, 0);
            cyc(0, 0, 1, 0);
            if (carro_amarelo && clear_Reg05s) n++;
        end
        check("yel_clr", 16'(n), 16'd4);
        check("vermelho", 16'({carro_vermelho, pedestre_verde}), 16'b11);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < PB; i++) begin
            cyc(0, 0, 0, 0);
            pat[i] = pedestre_vermelho;
            cyc(0, 0, 1, 0);
        end
        check("blink", 16'(pat), 16'b101010);
        check("back_verde", 16'(clear_Reg7s & carro_verde), 16'd1);
        repeat (4) cyc(0, 1, 1, 0);
        check("foreign", 16'(dout), 16'b10000010001);
`ifdef PED_REQ_EN
        repeat (100) cyc(1, 0, 0, 0);
        check("no_req", 16'(carro_verde & load_Reg7s), 16'd1);
        cyc(1, 0, 0, 1);
        check("ped_go", 16'({pend_o, carro_amarelo}), 16'b11);
        repeat (YH) begin
            cyc(0, 0, 0, 0);
            cyc(0, 0, 1, 0);
        end
        check("pend_clr", 16'({pend_o, carro_vermelho}), 16'b01);
`else
        cyc(1, 0, 0, 0);
        check("go7", 16'(carro_amarelo), 16'd1);
`endif
        rand_run(400);
        #2 rst = 1'b1;
        #1 check("async_rst", 16'(dout), 16'(RST_W));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 0, 0, 0);
        rand_run(100);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
